// File: rtl/exwb_forward_datapath.sv
// Execute/memory/writeback datapath: register file, operand forwarding, ALU,
// synchronous data memory and the result pipeline that the forwarding selects index.
module exwb_forward_datapath #(
  parameter int DMEM_AW = 8,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op_dec,
  input  logic [15:0]     imm,
  input  logic            imm_sel,
  input  logic [1:0]      mux_sel_A,
  input  logic [1:0]      mux_sel_B,
  input  logic [4:0]      ra_addr,
  input  logic [4:0]      rb_addr,
  input  logic            mem_en_ex,
  input  logic            mem_rw_ex,
  input  logic            mem_mux_sel_dm,
  input  logic [4:0]      RW_dm,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_addr,
  output logic            wb_we,
  output logic [XLEN-1:0] alu_result
);

  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] mem [2**DMEM_AW];

  logic [XLEN-1:0] alu_q, st_d, mem_q, dmem_q, wb_q;
  logic            we1, we2;

  logic [XLEN-1:0] rf_a, rf_b, fwd_a, fwd_b, op_b, imm_ext, alu_d;
  logic            we0;
  logic [DMEM_AW-1:0] mem_addr;

  // Reads see the pre-write value; same-cycle bypass is the job of select 10.
  assign rf_a = (ra_addr == 5'd0) ? '0 : rf[ra_addr];
  assign rf_b = (rb_addr == 5'd0) ? '0 : rf[rb_addr];

  always_comb begin
    fwd_a = rf_a;
    case (mux_sel_A)
      2'b00:   fwd_a = rf_a;
      2'b01:   fwd_a = alu_q;
      2'b10:   fwd_a = wb_data;
      default: fwd_a = wb_q;
    endcase
  end

  always_comb begin
    fwd_b = rf_b;
    case (mux_sel_B)
      2'b00:   fwd_b = rf_b;
      2'b01:   fwd_b = alu_q;
      2'b10:   fwd_b = wb_data;
      default: fwd_b = wb_q;
    endcase
  end

  assign imm_ext = {{(XLEN-16){imm[15]}}, imm};
  assign op_b    = imm_sel ? imm_ext : fwd_b;

  always_comb begin
    alu_d = fwd_a + op_b;
    if (op_dec[5:4] != 2'b01) begin
      case (op_dec[2:0])
        3'b000:  alu_d = fwd_a + op_b;
        3'b001:  alu_d = fwd_a - op_b;
        3'b010:  alu_d = fwd_a & op_b;
        3'b011:  alu_d = fwd_a | op_b;
        3'b100:  alu_d = fwd_a ^ op_b;
        3'b101:  alu_d = ~(fwd_a | op_b);
        3'b110:  alu_d = ($signed(fwd_a) < $signed(op_b)) ? XLEN'(1) : '0;
        default: alu_d = fwd_a << op_b[4:0];
      endcase
    end
  end

  // Stores and the 011xxx class never write back.
  assign we0 = !((op_dec == 6'b010101) || (op_dec[5:3] == 3'b011));

  assign mem_addr = alu_q[DMEM_AW-1:0];
  assign wb_data  = mem_mux_sel_dm ? dmem_q : mem_q;
  assign wb_we    = we2 & (RW_dm != 5'd0);
  assign wb_addr  = RW_dm;
  assign alu_result = alu_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q  <= '0;
      st_d   <= '0;
      mem_q  <= '0;
      dmem_q <= '0;
      wb_q   <= '0;
      we1    <= 1'b0;
      we2    <= 1'b0;
    end else begin
      alu_q <= alu_d;
      st_d  <= fwd_b;
      we1   <= we0;
      we2   <= we1;
      mem_q <= alu_q;
      wb_q  <= wb_data;
      if (mem_en_ex && !mem_rw_ex) dmem_q <= mem[mem_addr];
    end
  end

  // Data memory contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && mem_en_ex && mem_rw_ex) mem[mem_addr] <= st_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[RW_dm] <= wb_data;
    end
  end

endmodule
